// File: rtl/ir_pkg.sv
// Shared types and default sizing for the image-row scheduler and its coordinate counter.
package ir_pkg;
   localparam int IR_ROW_COUNT  = 4;
   localparam int IR_ADDR_WIDTH = 8;
   localparam int IR_CH_WIDTH   = 4;

   typedef enum logic [2:0] {
      IDLE, INIT, COORD_GEN, WRITE_STALL, TILE_CMP, DATA_OUT
   } ir_state_e;

   // One-cycle commands from the controller to the coordinate counter.
   typedef struct packed {
      logic clr;
      logic save;
      logic restore;
      logic row_clr;
      logic step;
   } ir_cnt_cmd_t;
endpackage

// File: rtl/ir_coord_counter.sv
// Walks the output map (y inner, x outer, stride step), counts rows within a tile and
// keeps the tile base so a tile can be replayed for every input channel.
module ir_coord_counter
   import ir_pkg::*;
#(
   parameter int ROW_COUNT  = IR_ROW_COUNT,
   parameter int ADDR_WIDTH = IR_ADDR_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  ir_cnt_cmd_t                  i_cmd,
   input  logic [ADDR_WIDTH-1:0]        i_width,
   input  logic [ADDR_WIDTH-1:0]        i_height,
   input  logic [ADDR_WIDTH-1:0]        i_stride,
   output logic [ADDR_WIDTH-1:0]        o_x,
   output logic [ADDR_WIDTH-1:0]        o_y,
   output logic [$clog2(ROW_COUNT)-1:0] o_row,
   output logic                         o_last,
   output logic                         o_tile_end
);
   localparam int RW = $clog2(ROW_COUNT);
   localparam int W2 = 2 * ADDR_WIDTH;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROW_COUNT - 1);

   logic [W2-1:0] x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d;
   logic [W2-1:0] x_lim, y_lim, step_w;
   logic [RW-1:0] row_q, row_d;

   // Limits at double width so (size-1)*stride can never wrap.
   assign x_lim  = W2'(i_width - ADDR_WIDTH'(1)) * W2'(i_stride);
   assign y_lim  = W2'(i_height - ADDR_WIDTH'(1)) * W2'(i_stride);
   assign step_w = W2'(i_stride);

   assign o_last     = (x_q >= x_lim) && (y_q >= y_lim);
   assign o_tile_end = (row_q == ROW_LAST);
   assign o_x        = x_q[ADDR_WIDTH-1:0];
   assign o_y        = y_q[ADDR_WIDTH-1:0];
   assign o_row      = row_q;

   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      bx_d  = bx_q;
      by_d  = by_q;
      row_d = row_q;
      if (i_cmd.clr) begin
         x_d   = '0;
         y_d   = '0;
         bx_d  = '0;
         by_d  = '0;
         row_d = '0;
      end else begin
         if (i_cmd.save) begin
            bx_d = x_q;
            by_d = y_q;
         end
         if (i_cmd.restore) begin
            x_d = bx_q;
            y_d = by_q;
         end
         if (i_cmd.row_clr) row_d = '0;
         if (i_cmd.step) begin
            row_d = row_q + RW'(1);
            if (y_q >= y_lim) begin
               y_d = '0;
               x_d = x_q + step_w;
            end else begin
               y_d = y_q + step_w;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         x_q   <= '0;
         y_q   <= '0;
         bx_q  <= '0;
         by_q  <= '0;
         row_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         bx_q  <= bx_d;
         by_q  <= by_d;
         row_q <= row_d;
      end
   end
endmodule

// File: rtl/ir_sched_controller.sv
// Tile scheduler: emits ROW_COUNT coordinates per tile, waits for the row routers to drain,
// replays the tile per input channel, then advances to the next tile until the map is done.
module ir_sched_controller
   import ir_pkg::*;
#(
   parameter int ROW_COUNT  = IR_ROW_COUNT,
   parameter int ADDR_WIDTH = IR_ADDR_WIDTH,
   parameter int CH_WIDTH   = IR_CH_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  logic                         i_en,
   input  logic                         i_reg_clear,
   input  logic [ADDR_WIDTH-1:0]        i_o_width,
   input  logic [ADDR_WIDTH-1:0]        i_o_height,
   input  logic [ADDR_WIDTH-1:0]        i_stride,
   input  logic [CH_WIDTH-1:0]          i_ch_count,
   input  logic                         i_addr_empty,
   input  logic                         i_data_empty,
   input  logic                         i_pop_en,
   output logic [ADDR_WIDTH-1:0]        o_o_x,
   output logic [ADDR_WIDTH-1:0]        o_o_y,
   output logic [$clog2(ROW_COUNT)-1:0] o_row_id,
   output logic [CH_WIDTH-1:0]          o_ch_id,
   output logic                         o_row_valid,
   output logic [ROW_COUNT-1:0]         o_row_mask,
   output logic                         o_tile_read_en,
   output logic                         o_ac_en,
   output logic                         o_pop_en,
   output logic                         o_ready,
   output logic                         o_reg_clear,
   output logic                         o_context_done,
   output logic                         o_done
);
   ir_state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0]    w_q, w_d, h_q, h_d, s_q, s_d;
   logic [CH_WIDTH-1:0]      ch_max_q, ch_max_d, ch_q, ch_d;
   logic [ROW_COUNT-1:0]     mask_q, mask_d;
   logic                     cmp_q, cmp_d, ready_q, ready_d, pop_q, pop_d;
   logic                     rclr_q, rclr_d, ctx_q, ctx_d, done_q, done_d;
   logic                     map_done_q, map_done_d;
   ir_cnt_cmd_t              cmd;
   logic                     cnt_last, cnt_tile_end;

   ir_coord_counter #(.ROW_COUNT(ROW_COUNT), .ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
      .i_clk      (i_clk),
      .i_nrst     (i_nrst),
      .i_cmd      (cmd),
      .i_width    (w_q),
      .i_height   (h_q),
      .i_stride   (s_q),
      .o_x        (o_o_x),
      .o_y        (o_o_y),
      .o_row      (o_row_id),
      .o_last     (cnt_last),
      .o_tile_end (cnt_tile_end)
   );

   assign o_row_valid    = (state_q == COORD_GEN);
   assign o_ch_id        = ch_q;
   assign o_row_mask     = mask_q;
   assign o_tile_read_en = cmp_q;
   assign o_ac_en        = cmp_q;
   assign o_pop_en       = pop_q;
   assign o_ready        = ready_q;
   assign o_reg_clear    = rclr_q;
   assign o_context_done = ctx_q;
   assign o_done         = done_q;

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      h_d        = h_q;
      s_d        = s_q;
      ch_max_d   = ch_max_q;
      ch_d       = ch_q;
      mask_d     = mask_q;
      cmp_d      = cmp_q;
      ready_d    = ready_q;
      pop_d      = pop_q;
      rclr_d     = rclr_q;
      ctx_d      = ctx_q;
      done_d     = done_q;
      map_done_d = map_done_q;
      cmd        = '0;
      if (i_reg_clear) begin
         state_d    = IDLE;
         w_d        = '0;
         h_d        = '0;
         s_d        = '0;
         ch_max_d   = '0;
         ch_d       = '0;
         mask_d     = '0;
         cmp_d      = 1'b0;
         ready_d    = 1'b0;
         pop_d      = 1'b0;
         rclr_d     = 1'b0;
         ctx_d      = 1'b0;
         done_d     = 1'b0;
         map_done_d = 1'b0;
         cmd.clr    = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               rclr_d = 1'b0;
               ctx_d  = 1'b0;
               if (i_en && !done_q) begin
                  w_d        = i_o_width;
                  h_d        = i_o_height;
                  s_d        = i_stride;
                  // Zero channels behaves as a single channel.
                  ch_max_d   = (i_ch_count == '0) ? '0 : i_ch_count - CH_WIDTH'(1);
                  ch_d       = '0;
                  map_done_d = 1'b0;
                  cmd.clr    = 1'b1;
                  if (i_o_width == '0 || i_o_height == '0) done_d = 1'b1;
                  else                                     state_d = INIT;
               end
            end
            INIT: begin
               rclr_d      = 1'b0;
               ctx_d       = 1'b0;
               ready_d     = 1'b0;
               mask_d      = '0;
               cmd.save    = 1'b1;
               cmd.row_clr = 1'b1;
               state_d     = COORD_GEN;
            end
            COORD_GEN: begin
               mask_d = mask_q | (ROW_COUNT'(1) << o_row_id);
               // The final coordinate is held so replays restore from the saved base.
               if (cnt_last) begin
                  map_done_d = 1'b1;
                  state_d    = WRITE_STALL;
               end else begin
                  cmd.step = 1'b1;
                  if (cnt_tile_end) state_d = WRITE_STALL;
               end
            end
            WRITE_STALL: begin
               cmp_d   = 1'b1;
               state_d = TILE_CMP;
            end
            TILE_CMP: begin
               if (i_addr_empty) begin
                  cmp_d   = 1'b0;
                  ready_d = 1'b1;
                  pop_d   = 1'b1;
                  state_d = DATA_OUT;
               end
            end
            DATA_OUT: begin
               if (i_data_empty) begin
                  pop_d   = 1'b0;
                  ready_d = 1'b0;
                  rclr_d  = 1'b1;
                  if (ch_q != ch_max_q) begin
                     ch_d        = ch_q + CH_WIDTH'(1);
                     cmd.restore = 1'b1;
                     state_d     = INIT;
                  end else if (!map_done_q) begin
                     ch_d    = '0;
                     ctx_d   = 1'b1;
                     state_d = INIT;
                  end else begin
                     ch_d    = '0;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  pop_d = i_pop_en;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q    <= IDLE;
         w_q        <= '0;
         h_q        <= '0;
         s_q        <= '0;
         ch_max_q   <= '0;
         ch_q       <= '0;
         mask_q     <= '0;
         cmp_q      <= 1'b0;
         ready_q    <= 1'b0;
         pop_q      <= 1'b0;
         rclr_q     <= 1'b0;
         ctx_q      <= 1'b0;
         done_q     <= 1'b0;
         map_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         h_q        <= h_d;
         s_q        <= s_d;
         ch_max_q   <= ch_max_d;
         ch_q       <= ch_d;
         mask_q     <= mask_d;
         cmp_q      <= cmp_d;
         ready_q    <= ready_d;
         pop_q      <= pop_d;
         rclr_q     <= rclr_d;
         ctx_q      <= ctx_d;
         done_q     <= done_d;
         map_done_q <= map_done_d;
      end
   end
endmodule
